dual_xor_prbs_checker: RTL and testbench
========================================

# dual_xor_prbs_checker

Self-synchronising PRBS checker for the receive end of the dual-XOR test path. It consumes the decrypted serial stream, seeds a local LFSR from the first M received bits and predicts every later bit. Mismatches are counted, and it drops and re-acquires lock on sustained error bursts. It is the checker counterpart of the LFSR datastream generator and drives the board error LED.

## Interface
- `M`, 32, LFSR length in bits (≥ 2).
- `ERR_W`, 16, width of the saturating error counter.
- `WIN`, 64, lock-monitor window length in accepted bits.
- `LOSS_THR`, 8, errors within one window that force loss of lock (1 ≤ LOSS_THR ≤ WIN).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: qualifies `din`; one bit is accepted per cycle with `en`=1.
- `din` in 1: received (decrypted) bit.
- `taps` in M: feedback tap mask; static while `en` is active.
- `clr` in 1: synchronous clear of `error_counter` and `errors`.
- `locked` out 1: checker is in LOCK.
- `err_pulse` out 1: one-cycle strobe per mismatched bit.
- `error_counter` out ERR_W: saturating mismatch count.
- `errors` out 1: sticky flag, set on any mismatch since reset or `clr`.
- `relock_count` out 8: number of loss-of-lock events, saturating at 255.

## Operation
- Generator convention: `out = ^(state & taps)`, then `state <= {state[M-2:0], out}`.
- `pred = ^(state & taps)` is computed on the checker state. Every accepted bit does `state <= {state[M-2:0], din}`; the checker always shifts in the received bit, never the predicted one.
- States:
  - ACQ (reset state): count accepted bits in `fill` (0..M-1). On the M-th accepted bit, go to LOCK, unless the resulting state is all zeros. In that case, clear `fill` and stay in ACQ, so the checker never locks to an idle line. No comparisons are made in ACQ.
  - LOCK: compare each accepted `din` against `pred`.
    - On mismatch: pulse `err_pulse`, increment `error_counter` (stops at all-ones) and set `errors`.
    - Window counter `wcnt` counts 0..WIN-1 and wraps; window error count `werr` resets at each wrap.
    - When `werr` reaches LOSS_THR: go to ACQ, clear `fill`, `wcnt` and `werr`, and increment `relock_count`.
- A single flipped bit in LOCK produces exactly 1 + popcount(`taps`) mismatches, because the bad bit propagates through the taps. It does not cause loss of lock when LOSS_THR exceeds that count.
- `en`=0 holds all state; `err_pulse` is 0.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `error_counter`=0, `errors`=0, `relock_count`=0; internally state=0, FSM=ACQ, `fill`, `wcnt` and `werr` all 0.
- All outputs are registered.
- `err_pulse`, `error_counter` and `errors` update on the clock edge that accepts the offending bit, so they are visible the cycle after `din` is presented.
- `locked` rises on the edge accepting the M-th acquisition bit. It falls on the edge accepting the bit that brings `werr` to LOSS_THR. That bit is still counted as an error.
- Simultaneous events:
  - Threshold reached on the window-wrap bit: loss of lock takes priority.
  - `clr` together with a mismatch: `clr` wins, so the counter and `errors` are 0 and `err_pulse` still fires.
  - `clr` does not affect lock state or `relock_count`.
- Asserting `rst` mid-operation returns the block to reset values immediately (asynchronous); acquisition restarts from `fill`=0.

## Structure
- Shared package `dual_xor_pkg`: holds the checker FSM enum (ACQ, LOCK), the default M, and the function `lfsr_parity(state, taps)`. The generator uses the same function.
- No sub-module is needed; the window and threshold logic stays inline.

## Test plan
- Lock and clean run: `taps`=0x48000000, generator seed 0x55, `en`=1 continuously, 1000 bits → `locked`=1 from bit 32 onward, `error_counter`=0, `errors`=0.
- Single bit flip at bit 200: expect 3 `err_pulse` strobes, `error_counter`=3, `errors`=1, `locked` stays 1, `relock_count`=0.
- Burst of 20 random bits while locked with defaults: `locked` falls on the 8th mismatch in the window, `relock_count`=1. The checker relocks 32 clean bits after the burst ends, then shows zero new errors.
- All-zero input for 200 bits → `locked` never asserts, counters stay 0.
- Counter saturation and clear with `ERR_W`=4 and an inverted stream with LOSS_THR=WIN=64 → counter holds at 15. `clr` asserted in the same cycle as a mismatch → `error_counter`=0, `errors`=0, `err_pulse`=1.
- `rst` pulsed mid-LOCK, including with `en` gapped every other cycle → all outputs 0 immediately; the checker relocks after 32 accepted bits, regardless of gaps.

Source files
------------

// File: rtl/dual_xor_pkg.sv
// Shared definitions for the dual-XOR test path (PRBS generator and checker).
//   chk_state_e  : checker FSM states (ACQ = acquiring seed, LOCK = predicting)
//   M_DEFAULT    : default LFSR length
//   lfsr_parity  : feedback/prediction bit, ^(state & taps), for LFSRs up to
//                  LFSR_MAX_W bits (callers zero-extend narrower vectors)
package dual_xor_pkg;

  typedef enum logic {
    ACQ  = 1'b0,
    LOCK = 1'b1
  } chk_state_e;

  localparam int unsigned M_DEFAULT  = 32;
  localparam int unsigned LFSR_MAX_W = 64;

  function automatic logic lfsr_parity(input logic [LFSR_MAX_W-1:0] state,
                                       input logic [LFSR_MAX_W-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/dual_xor_prbs_checker.sv
// Self-synchronising PRBS checker. Seeds its LFSR from the first M accepted
// bits, then predicts each bit and counts mismatches; sustained error bursts
// (LOSS_THR errors inside a WIN-bit window) drop lock and restart acquisition.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   en, din         : bit-valid qualifier and received bit
//   taps [M]        : feedback tap mask (static while en is active)
//   clr             : synchronous clear of error_counter and errors
//   locked          : checker is in LOCK
//   err_pulse       : one-cycle strobe per mismatched bit
//   error_counter   : saturating mismatch count
//   errors          : sticky mismatch flag
//   relock_count    : saturating count of loss-of-lock events
module dual_xor_prbs_checker
  import dual_xor_pkg::*;
#(
  parameter int unsigned M        = M_DEFAULT,
  parameter int unsigned ERR_W    = 16,
  parameter int unsigned WIN      = 64,
  parameter int unsigned LOSS_THR = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic [M-1:0]     taps,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] error_counter,
  output logic             errors,
  output logic [7:0]       relock_count
);

  localparam int unsigned FILL_W = $clog2(M);
  localparam int unsigned WCNT_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned WERR_W = $clog2(LOSS_THR + 1);

  chk_state_e        state_q, state_d;
  logic [M-1:0]      sr_q, sr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [WERR_W-1:0] werr_q, werr_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  errcnt_q, errcnt_d;
  logic              errors_q, errors_d;
  logic [7:0]        relock_q, relock_d;

  logic [M-1:0] shifted;
  logic         pred, mism, fill_done, seed_zero, thr_hit, wrap;

  // The received bit is always shifted in, never the prediction: this is what
  // makes the checker self-synchronising after M clean bits.
  always_comb begin
    shifted   = {sr_q[M-2:0], din};
    pred      = lfsr_parity(LFSR_MAX_W'(sr_q), LFSR_MAX_W'(taps));
    mism      = en && (state_q == LOCK) && (din != pred);
    fill_done = en && (state_q == ACQ) && (fill_q == FILL_W'(M - 1));
    seed_zero = (shifted == '0);
    thr_hit   = mism && (werr_q == WERR_W'(LOSS_THR - 1));
    wrap      = (wcnt_q == WCNT_W'(WIN - 1));
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACQ;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACQ:  if (fill_done && !seed_zero) state_d = LOCK;
      LOCK: if (thr_hit)                 state_d = ACQ;
      default: state_d = ACQ;
    endcase
  end

  // FSM: outputs
  always_comb begin
    locked = (state_q == LOCK);
  end

  // Datapath next-state
  always_comb begin
    sr_d        = sr_q;
    fill_d      = fill_q;
    wcnt_d      = wcnt_q;
    werr_d      = werr_q;
    relock_d    = relock_q;
    err_pulse_d = mism;

    if (en) begin
      sr_d = shifted;
      if (state_q == ACQ) begin
        fill_d = fill_done ? '0 : fill_q + 1'b1;
      end else if (thr_hit) begin
        // Loss of lock outranks a simultaneous window wrap.
        fill_d = '0;
        wcnt_d = '0;
        werr_d = '0;
        if (relock_q != '1) relock_d = relock_q + 1'b1;
      end else if (wrap) begin
        wcnt_d = '0;
        werr_d = '0;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
        werr_d = werr_q + WERR_W'(mism);
      end
    end

    // clr wins over a coincident mismatch; err_pulse is unaffected.
    if (clr) begin
      errcnt_d = '0;
      errors_d = 1'b0;
    end else begin
      errcnt_d = (mism && errcnt_q != '1) ? errcnt_q + 1'b1 : errcnt_q;
      errors_d = errors_q | mism;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q        <= '0;
      fill_q      <= '0;
      wcnt_q      <= '0;
      werr_q      <= '0;
      err_pulse_q <= 1'b0;
      errcnt_q    <= '0;
      errors_q    <= 1'b0;
      relock_q    <= '0;
    end else begin
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      wcnt_q      <= wcnt_d;
      werr_q      <= werr_d;
      err_pulse_q <= err_pulse_d;
      errcnt_q    <= errcnt_d;
      errors_q    <= errors_d;
      relock_q    <= relock_d;
    end
  end

  assign err_pulse     = err_pulse_q;
  assign error_counter = errcnt_q;
  assign errors        = errors_q;
  assign relock_count  = relock_q;

endmodule

// File: tb/tb_dual_xor_prbs_checker.sv
module tb_dual_xor_prbs_checker;

  localparam int TB_M     = 32;
  localparam int LOSS_THR = 8;
  localparam int WIN      = 64;
  localparam int ERR_MAX  = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        din = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] taps = 32'h4800_0000;

  logic        locked, err_pulse, errors;
  logic [15:0] error_counter;
  logic [7:0]  relock_count;

  logic        locked2, err_pulse2, errors2;
  logic [3:0]  error_counter2;
  logic [7:0]  relock_count2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dual_xor_prbs_checker #(.M(32), .ERR_W(16), .WIN(64), .LOSS_THR(8)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .taps(taps), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .error_counter(error_counter),
    .errors(errors), .relock_count(relock_count)
  );

  dual_xor_prbs_checker #(.M(32), .ERR_W(4), .WIN(64), .LOSS_THR(64)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .din(din), .taps(taps), .clr(clr),
    .locked(locked2), .err_pulse(err_pulse2), .error_counter(error_counter2),
    .errors(errors2), .relock_count(relock_count2)
  );

  // ---------------- behavioural reference (main instance) ----------------
  bit hist[$];        // hist[k] = bit received k accepted bits ago
  int m_fill, m_wcnt, m_werr, m_errcnt, m_relock;
  bit m_locked, m_errors, m_pulse;

  // ---------------- generator ----------------
  logic [31:0] gstate;

  task automatic gen_next(output bit b);
    b = ^(gstate & taps);
    gstate = {gstate[30:0], b};
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < TB_M; i++) hist.push_back(1'b0);
    m_fill = 0; m_wcnt = 0; m_werr = 0; m_errcnt = 0; m_relock = 0;
    m_locked = 0; m_errors = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit e, input bit b, input bit c);
    bit pred;
    bit any_one;
    m_pulse = 0;
    if (e) begin
      if (m_locked) begin
        pred = 0;
        for (int k = 0; k < TB_M; k++) if (taps[k]) pred ^= hist[k];
        if (b != pred) begin
          m_pulse = 1;
          if (m_errcnt < ERR_MAX) m_errcnt++;
          m_errors = 1;
          m_werr++;
        end
        if (m_werr == LOSS_THR) begin
          m_locked = 0; m_fill = 0; m_wcnt = 0; m_werr = 0;
          if (m_relock < 255) m_relock++;
        end else begin
          m_wcnt++;
          if (m_wcnt == WIN) begin m_wcnt = 0; m_werr = 0; end
        end
        hist.push_front(b); void'(hist.pop_back());
      end else begin
        hist.push_front(b); void'(hist.pop_back());
        m_fill++;
        if (m_fill == TB_M) begin
          m_fill = 0;
          any_one = 0;
          for (int k = 0; k < TB_M; k++) any_one |= hist[k];
          if (any_one) m_locked = 1;
        end
      end
    end
    if (c) begin m_errcnt = 0; m_errors = 0; end
  endtask

  // Drive one cycle: inputs applied 1 time unit after an edge, sampled 1 after the next.
  task automatic drive(input bit e, input bit b, input bit c);
    en = e; din = b; clr = c;
    @(posedge clk); #1;
    model_step(e, b, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    en = 0; din = 0; clr = 0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; en = 0; din = 0; clr = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || error_counter !== 16'd0 ||
        errors !== 1'b0 || relock_count !== 8'd0) begin
      n_errors++;
      $display("FAIL reset: got locked=%b pulse=%b cnt=%0d errors=%b relock=%0d, expected all 0",
               locked, err_pulse, error_counter, errors, relock_count);
    end
    n_checks++;
    if (locked2 !== 1'b0 || err_pulse2 !== 1'b0 || error_counter2 !== 4'd0 ||
        errors2 !== 1'b0 || relock_count2 !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_sat: got locked=%b pulse=%b cnt=%0d errors=%b relock=%0d, expected all 0",
               locked2, err_pulse2, error_counter2, errors2, relock_count2);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_lock();
    bit b;
    do_reset();
    gstate = 32'h55;
    for (int i = 1; i <= 1000; i++) begin
      gen_next(b);
      drive(1'b1, b, 1'b0);
      n_checks++;
      if (locked !== m_locked || locked !== (i >= 32) || err_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL clean_lock bit %0d: locked=%b pulse=%b, expected locked=%b pulse=0",
                 i, locked, err_pulse, (i >= 32));
      end
    end
    n_checks++;
    if (error_counter !== 16'd0 || errors !== 1'b0 || relock_count !== 8'd0) begin
      n_errors++;
      $display("FAIL clean_end: cnt=%0d errors=%b relock=%0d, expected 0 0 0",
               error_counter, errors, relock_count);
    end
  endtask

  task automatic test_single_flip();
    bit b;
    int pulses = 0;
    do_reset();
    gstate = 32'h55;
    for (int i = 1; i <= 1000; i++) begin
      gen_next(b);
      drive(1'b1, (i == 200) ? ~b : b, 1'b0);
      if (err_pulse === 1'b1) pulses++;
      n_checks++;
      if (err_pulse !== m_pulse || locked !== m_locked) begin
        n_errors++;
        $display("FAIL single_flip bit %0d: pulse=%b locked=%b, expected %b %b",
                 i, err_pulse, locked, m_pulse, m_locked);
      end
    end
    n_checks++;
    if (pulses != 3 || error_counter !== 16'd3 || errors !== 1'b1 ||
        locked !== 1'b1 || relock_count !== 8'd0) begin
      n_errors++;
      $display("FAIL single_flip_end: pulses=%0d cnt=%0d errors=%b locked=%b relock=%0d, expected 3 3 1 1 0",
               pulses, error_counter, errors, locked, relock_count);
    end
  endtask

  task automatic test_burst();
    bit b;
    logic [15:0] snap;
    do_reset();
    gstate = 32'h1234_5678;
    for (int i = 0; i < 100; i++) begin gen_next(b); drive(1'b1, b, 1'b0); end
    for (int i = 0; i < 20; i++) begin
      gen_next(b);
      drive(1'b1, 1'($urandom), 1'b0);
      n_checks++;
      if (err_pulse !== m_pulse || locked !== m_locked || error_counter !== 16'(m_errcnt) ||
          relock_count !== 8'(m_relock)) begin
        n_errors++;
        $display("FAIL burst %0d: pulse=%b locked=%b cnt=%0d relock=%0d, expected %b %b %0d %0d",
                 i, err_pulse, locked, error_counter, relock_count,
                 m_pulse, m_locked, m_errcnt, m_relock);
      end
    end
    for (int i = 0; i < 300; i++) begin
      gen_next(b);
      drive(1'b1, b, 1'b0);
      n_checks++;
      if (err_pulse !== m_pulse || locked !== m_locked || relock_count !== 8'(m_relock)) begin
        n_errors++;
        $display("FAIL burst_recover %0d: pulse=%b locked=%b relock=%0d, expected %b %b %0d",
                 i, err_pulse, locked, relock_count, m_pulse, m_locked, m_relock);
      end
    end
    snap = error_counter;
    for (int i = 0; i < 100; i++) begin gen_next(b); drive(1'b1, b, 1'b0); end
    n_checks++;
    if (locked !== 1'b1 || error_counter !== snap || error_counter !== 16'(m_errcnt) ||
        relock_count === 8'd0) begin
      n_errors++;
      $display("FAIL burst_end: locked=%b cnt=%0d (before %0d, model %0d) relock=%0d, expected locked, stable, relock>0",
               locked, error_counter, snap, m_errcnt, relock_count);
    end
  endtask

  task automatic test_all_zero();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (locked !== 1'b0 || err_pulse !== 1'b0 || error_counter !== 16'd0) begin
        n_errors++;
        $display("FAIL all_zero %0d: locked=%b pulse=%b cnt=%0d, expected 0 0 0",
                 i, locked, err_pulse, error_counter);
      end
    end
  endtask

  task automatic test_saturation_clear();
    bit b;
    do_reset();
    gstate = 32'h55;
    // Even tap count: an inverted stream mispredicts every bit once locked.
    for (int i = 0; i < 52; i++) begin gen_next(b); drive(1'b1, ~b, 1'b0); end
    n_checks++;
    if (locked2 !== 1'b1 || error_counter2 !== 4'd15 || errors2 !== 1'b1) begin
      n_errors++;
      $display("FAIL saturate: locked=%b cnt=%0d errors=%b, expected 1 15 1",
               locked2, error_counter2, errors2);
    end
    gen_next(b); drive(1'b1, ~b, 1'b1);
    n_checks++;
    if (err_pulse2 !== 1'b1 || error_counter2 !== 4'd0 || errors2 !== 1'b0 || locked2 !== 1'b1) begin
      n_errors++;
      $display("FAIL clr_with_err: pulse=%b cnt=%0d errors=%b locked=%b, expected 1 0 0 1",
               err_pulse2, error_counter2, errors2, locked2);
    end
    n_checks++;
    if (err_pulse !== m_pulse || error_counter !== 16'(m_errcnt) || errors !== m_errors ||
        locked !== m_locked || relock_count !== 8'(m_relock)) begin
      n_errors++;
      $display("FAIL clr_main: pulse=%b cnt=%0d errors=%b locked=%b relock=%0d, expected %b %0d %b %b %0d",
               err_pulse, error_counter, errors, locked, relock_count,
               m_pulse, m_errcnt, m_errors, m_locked, m_relock);
    end
    gen_next(b); drive(1'b1, ~b, 1'b0);
    n_checks++;
    if (error_counter2 !== 4'd1 || errors2 !== 1'b1) begin
      n_errors++;
      $display("FAIL after_clr: cnt=%0d errors=%b, expected 1 1", error_counter2, errors2);
    end
  endtask

  task automatic test_rst_midlock();
    bit b;
    int accepted = 0;
    do_reset();
    gstate = 32'hACE1;
    for (int i = 1; i <= 80; i++) begin gen_next(b); drive(1'b1, (i == 40) ? ~b : b, 1'b0); end
    n_checks++;
    if (locked !== 1'b1 || error_counter !== 16'd3 || errors !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_rst: locked=%b cnt=%0d errors=%b, expected 1 3 1", locked, error_counter, errors);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || error_counter !== 16'd0 ||
        errors !== 1'b0 || relock_count !== 8'd0) begin
      n_errors++;
      $display("FAIL async_rst: locked=%b pulse=%b cnt=%0d errors=%b relock=%0d, expected all 0",
               locked, err_pulse, error_counter, errors, relock_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 0) begin
        gen_next(b); drive(1'b1, b, 1'b0); accepted++;
      end else begin
        drive(1'b0, 1'b1, 1'b0);
      end
      n_checks++;
      if (locked !== m_locked || locked !== (accepted >= 32) || err_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL gapped_relock cyc %0d: locked=%b pulse=%b, expected locked=%b pulse=0",
                 i, locked, err_pulse, (accepted >= 32));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_lock();
    test_single_flip();
    test_burst();
    test_all_zero();
    test_saturation_clear();
    test_rst_midlock();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
